clk_en_rst_gen: RTL and testbench

Reset and clock-enable generator directly downstream of the board PLL wrapper. Runs on the PLL's 48 MHz output and takes the PLL `locked` flag as an asynchronous input. Holds core reset until lock has been stable for a programmable interval. Then produces phase-aligned single-cycle clock enables at 24/12/6/3 MHz for the game core, and re-asserts reset whenever lock is lost.

---
 rtl/clk_en_rst_gen.sv | 104 ++++++++++
 tb/tb_clk_en_rst_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clk_en_rst_gen.sv
// Core reset and clock-enable generator: releases sys_rst once PLL lock has been
// stable for HOLD_CYCLES, then emits phase-aligned 24/12/6/3 MHz enables from 48 MHz.
module clk_en_rst_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       sw_rst,
    output logic       sys_rst,
    output logic       ce_24m,
    output logic       ce_12m,
    output logic       ce_6m,
    output logic       ce_3m,
    output logic [7:0] lost_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [3:0]             div_q, div_d;
    logic [7:0]             lost_q, lost_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   lock_s;
    logic                   run;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], locked};

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lost_d  = lost_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (!lock_s || sw_rst) begin
                    state_d = WAIT_LOCK;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                // Lock loss wins over sw_rst so a coincident loss is still counted.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end else if (sw_rst) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign run       = (state_q == RUN);
    assign sys_rst_d = (state_d != RUN);
    assign div_d     = run ? div_q + 4'd1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            sync_q    <= '0;
            hold_q    <= '0;
            div_q     <= '0;
            lost_q    <= '0;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hold_q    <= hold_d;
            div_q     <= div_d;
            lost_q    <= lost_d;
            sys_rst_q <= sys_rst_d;
        end
    end

    assign sys_rst  = sys_rst_q;
    assign ce_24m   = run & div_q[0];
    assign ce_12m   = run & (&div_q[1:0]);
    assign ce_6m    = run & (&div_q[2:0]);
    assign ce_3m    = run & (&div_q[3:0]);
    assign lost_cnt = lost_q;

endmodule

// File: tb/tb_clk_en_rst_gen.sv
// Directed bench for clk_en_rst_gen with SYNC_STAGES=2, HOLD_CYCLES=4.
module tb_clk_en_rst_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       sw_rst;
    logic       sys_rst;
    logic       ce_24m, ce_12m, ce_6m, ce_3m;
    logic [7:0] lost_cnt;

    int vectors = 0;
    int miscompares = 0;

    clk_en_rst_gen #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .sw_rst   (sw_rst),
        .sys_rst  (sys_rst),
        .ce_24m   (ce_24m),
        .ce_12m   (ce_12m),
        .ce_6m    (ce_6m),
        .ce_3m    (ce_3m),
        .lost_cnt (lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks until sys_rst falls; returns the number of edges taken (bounded).
    task automatic edges_to_release(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sys_rst && n < 64);
    endtask

    task automatic chk_ce(input string tag, input int k);
        chk({tag, "_ce24"}, {31'd0, ce_24m}, {31'd0, (k % 2) == 1});
        chk({tag, "_ce12"}, {31'd0, ce_12m}, {31'd0, (k % 4) == 3});
        chk({tag, "_ce6"},  {31'd0, ce_6m},  {31'd0, (k % 8) == 7});
        chk({tag, "_ce3"},  {31'd0, ce_3m},  {31'd0, (k % 16) == 15});
    endtask

    initial begin
        int n;
        int c24, c12, c6, c3;
        bit early;

        // Power-up with lock already steady
        rst = 1'b1; locked = 1'b1; sw_rst = 1'b0;
        tick(); tick();
        chk("rst_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("rst_ce", {28'd0, ce_24m, ce_12m, ce_6m, ce_3m}, 32'd0);
        chk("rst_lost", {24'd0, lost_cnt}, 32'd0);
        rst = 1'b0;
        edges_to_release(n);
        chk("pwrup_release_edges", n, 32'd7);

        c24 = 0; c12 = 0; c6 = 0; c3 = 0;
        for (int k = 0; k < 32; k++) begin
            chk_ce("pwrup", k);
            c24 += int'(ce_24m); c12 += int'(ce_12m); c6 += int'(ce_6m); c3 += int'(ce_3m);
            tick();
        end
        chk("cnt_ce24", c24, 32'd16);
        chk("cnt_ce12", c12, 32'd8);
        chk("cnt_ce6",  c6,  32'd4);
        chk("cnt_ce3",  c3,  32'd2);

        // Lock loss in RUN
        locked = 1'b0;
        tick(); tick();
        chk("loss_sys_rst_e2", {31'd0, sys_rst}, 32'd0);
        tick();
        chk("loss_sys_rst_e3", {31'd0, sys_rst}, 32'd1);
        chk("loss_ce", {28'd0, ce_24m, ce_12m, ce_6m, ce_3m}, 32'd0);
        chk("loss_lost", {24'd0, lost_cnt}, 32'd1);
        tick(); tick();
        locked = 1'b1;
        edges_to_release(n);
        chk("relock_release_edges", n, 32'd7);
        for (int k = 0; k < 4; k++) begin
            chk_ce("relock", k);
            tick();
        end

        // Soft reset in RUN
        sw_rst = 1'b1;
        tick();
        chk("sw_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("sw_lost", {24'd0, lost_cnt}, 32'd1);
        chk("sw_ce", {28'd0, ce_24m, ce_12m, ce_6m, ce_3m}, 32'd0);
        sw_rst = 1'b0;
        edges_to_release(n);
        chk("sw_release_edges", n, 32'd5);

        // Glitch during HOLD restarts the interval
        rst = 1'b1; locked = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        early = 1'b0;
        locked = 1'b1;
        for (int k = 0; k < 4; k++) begin tick(); if (!sys_rst) early = 1'b1; end
        locked = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); if (!sys_rst) early = 1'b1; end
        chk("glitch_no_early_release", {31'd0, early}, 32'd0);
        locked = 1'b1;
        edges_to_release(n);
        chk("glitch_release_edges", n, 32'd7);
        chk("glitch_lost", {24'd0, lost_cnt}, 32'd0);

        // Saturation of lost_cnt
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            tick(); tick(); tick();
            locked = 1'b1;
            for (int j = 0; j < 7; j++) tick();
            if (i == 9) chk("sat_lost_10", {24'd0, lost_cnt}, 32'd10);
        end
        chk("sat_running", {31'd0, sys_rst}, 32'd0);
        chk("sat_lost_255", {24'd0, lost_cnt}, 32'd255);
        locked = 1'b0;
        tick(); tick(); tick();
        chk("sat_hold_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("sat_hold_255", {24'd0, lost_cnt}, 32'd255);
        locked = 1'b1;
        edges_to_release(n);
        chk("sat_release_edges", n, 32'd7);

        // Asynchronous reset mid-run
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("async_lost", {24'd0, lost_cnt}, 32'd0);
        chk("async_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("async_ce", {28'd0, ce_24m, ce_12m, ce_6m, ce_3m}, 32'd0);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
